arb_muxn: RTL and testbench



---
 rtl/arb_muxn.sv | 105 ++++++++++
 tb/tb_arb_muxn.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_muxn.sv
// N-channel valid/ready stream multiplexer with fixed-priority or round-robin
// arbitration, packet locking on `last`, and a registered output stage.
module arb_muxn #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned RR    = 1,
    parameter int unsigned SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  lock_ch;
    logic             locked;
    logic             load;
    logic             grant_valid;
    logic [SELW-1:0]  grant;
    logic [SELW-1:0]  cand;
    logic [WIDTH-1:0] grant_data;
    logic             grant_last;
    logic [SELW-1:0]  next_ptr;

    assign load = !out_valid || out_ready;

    // A locked packet owns the port; otherwise scan from ptr (RR) or from 0.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        cand        = '0;
        if (locked) begin
            grant_valid = in_valid[lock_ch];
            grant       = lock_ch;
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                if (RR != 0) begin
                    cand = SELW'((32'(ptr) + k) % N);
                end else begin
                    cand = SELW'(k);
                end
                if (!grant_valid && in_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant       = cand;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
            in_ready[i] = !reset && load && grant_valid && (grant == SELW'(i));
        end
    end

    assign grant_last = in_last[grant];
    assign next_ptr   = (grant == LAST_CH) ? '0 : grant + SELW'(1);

    // Output register, lock state and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
            ptr       <= '0;
            locked    <= 1'b0;
            lock_ch   <= '0;
        end else if (load) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_last  <= grant_last;
                out_sel   <= grant;
                if (grant_last) begin
                    locked <= 1'b0;
                    if (RR != 0) begin
                        ptr <= next_ptr;
                    end
                end else begin
                    locked  <= 1'b1;
                    lock_ch <= grant;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_muxn.sv
// Bench for arb_muxn: fixed-priority (index 0) and round-robin (index 1) instances,
// queue-fed producers, a behavioural reference model and a consumer scoreboard.
module tb_arb_muxn;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [3:0] gap;
    } beat_t;

    logic             clk;
    logic             reset;
    logic             out_ready;
    logic [1:0][31:0] dat;
    logic [1:0][3:0]  vld;
    logic [1:0][3:0]  lst;
    logic [1:0][3:0]  rdy;
    logic [1:0][7:0]  od;
    logic [1:0]       ov;
    logic [1:0]       ol;
    logic [1:0][1:0]  os;

    beat_t mem [2][4][16];
    int    hd [2][4];
    int    tl [2][4];
    int    rx [2][4];
    int    wt [2][4];

    bit         mv [2];
    bit         ml [2];
    bit         mlocked [2];
    logic [7:0] md [2];
    int         ms [2];
    int         mlch [2];
    int         mptr [2];

    int n_cmp;
    int n_bad;

    arb_muxn #(.WIDTH(8), .N(4), .RR(0)) u_fp (
        .clk(clk), .reset(reset), .in_data(dat[0]), .in_valid(vld[0]), .in_last(lst[0]),
        .in_ready(rdy[0]), .out_data(od[0]), .out_valid(ov[0]), .out_last(ol[0]),
        .out_sel(os[0]), .out_ready(out_ready)
    );

    arb_muxn #(.WIDTH(8), .N(4), .RR(1)) u_rr (
        .clk(clk), .reset(reset), .in_data(dat[1]), .in_valid(vld[1]), .in_last(lst[1]),
        .in_ready(rdy[1]), .out_data(od[1]), .out_valid(ov[1]), .out_last(ol[1]),
        .out_sel(os[1]), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int m, input int c, input logic [7:0] d, input logic l, input int g);
        mem[m][c][tl[m][c]] = '{data: d, last: l, gap: 4'(g)};
        tl[m][c]++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Literal expectation on one instance's output beat.
    task automatic lit(input string tag, input int m, input logic v, input int sel, input logic [7:0] d);
        check($sformatf("%s m%0d out_valid", tag, m), 32'(ov[m]), 32'(v));
        if (v) begin
            check($sformatf("%s m%0d out_sel", tag, m), 32'(os[m]), 32'(sel));
            check($sformatf("%s m%0d out_data", tag, m), 32'(od[m]), 32'(d));
        end
    endtask

    // Spec grant rule: locked channel only, else first valid scanning from ptr (RR) or 0.
    function automatic void mgrant(input int m, output bit gv, output int g);
        gv = 1'b0;
        g  = 0;
        if (mlocked[m]) begin
            gv = vld[m][mlch[m]];
            g  = mlch[m];
        end else begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m == 1) ? (mptr[m] + k) % 4 : k;
                if (!gv && vld[m][c]) begin
                    gv = 1'b1;
                    g  = c;
                end
            end
        end
    endfunction

    // Producers: present the head of each channel queue once its gap has elapsed.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int m = 0; m < 2; m++) begin
                for (int c = 0; c < 4; c++) begin
                    if (hd[m][c] < tl[m][c] && wt[m][c] == 0) begin
                        vld[m][c]          = 1'b1;
                        dat[m][c*8 +: 8]   = mem[m][c][hd[m][c]].data;
                        lst[m][c]          = mem[m][c][hd[m][c]].last;
                    end else begin
                        vld[m][c] = 1'b0;
                        lst[m][c] = 1'b0;
                    end
                end
            end
        end
    end

    // Reference model update on each clock edge.
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            bit gv;
            int g;
            for (int c = 0; c < 4; c++) begin
                if (wt[m][c] > 0) wt[m][c]--;
            end
            if (reset) begin
                mv[m] = 0; ml[m] = 0; md[m] = 8'h00; ms[m] = 0;
                mlocked[m] = 0; mlch[m] = 0; mptr[m] = 0;
            end else if (!mv[m] || out_ready) begin
                mgrant(m, gv, g);
                if (gv) begin
                    mv[m] = 1;
                    md[m] = dat[m][g*8 +: 8];
                    ml[m] = lst[m][g];
                    ms[m] = g;
                    if (ml[m]) begin
                        mlocked[m] = 0;
                        mptr[m]    = (g + 1) % 4;
                    end else begin
                        mlocked[m] = 1;
                        mlch[m]    = g;
                    end
                    hd[m][g]++;
                    wt[m][g] = (hd[m][g] < tl[m][g]) ? int'(mem[m][g][hd[m][g]].gap) : 0;
                end else begin
                    mv[m] = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus consumer-side scoreboard.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            bit         gv;
            int         g;
            int         c;
            logic [3:0] er;
            mgrant(m, gv, g);
            er = 4'b0000;
            if (!reset && (!mv[m] || out_ready) && gv) er[g] = 1'b1;
            check($sformatf("model m%0d in_ready", m), 32'(rdy[m]), 32'(er));
            check($sformatf("model m%0d out_valid", m), 32'(ov[m]), 32'(mv[m]));
            if (mv[m]) begin
                check($sformatf("model m%0d out_data", m), 32'(od[m]), 32'(md[m]));
                check($sformatf("model m%0d out_last", m), 32'(ol[m]), 32'(ml[m]));
                check($sformatf("model m%0d out_sel", m), 32'(os[m]), 32'(ms[m]));
            end
            if (ov[m] === 1'b1 && out_ready) begin
                c = int'(os[m]);
                check($sformatf("sb m%0d ch%0d beat available", m, c), 32'(rx[m][c] < tl[m][c]), 32'd1);
                if (rx[m][c] < tl[m][c]) begin
                    check($sformatf("sb m%0d ch%0d data", m, c), 32'(od[m]), 32'(mem[m][c][rx[m][c]].data));
                    check($sformatf("sb m%0d ch%0d last", m, c), 32'(ol[m]), 32'(mem[m][c][rx[m][c]].last));
                    rx[m][c]++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        out_ready = 1'b1;
        dat = '0;
        vld = '0;
        lst = '0;
        for (int m = 0; m < 2; m++) begin
            mv[m] = 0; ml[m] = 0; md[m] = 8'h00; ms[m] = 0;
            mlocked[m] = 0; mlch[m] = 0; mptr[m] = 0;
            for (int c = 0; c < 4; c++) begin
                hd[m][c] = 0; tl[m][c] = 0; rx[m][c] = 0; wt[m][c] = 0;
            end
        end

        // Reset with all four channels requesting; two single-beat packets each.
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 4; c++) begin
                    push(m, c, 8'hA0 + 8'(c), 1'b1, 0);
                end
            end
        end
        for (int r = 0; r < 2; r++) begin
            cyc();
            for (int m = 0; m < 2; m++) begin
                check($sformatf("reset m%0d in_ready", m), 32'(rdy[m]), 32'd0);
                check($sformatf("reset m%0d out_valid", m), 32'(ov[m]), 32'd0);
                check($sformatf("reset m%0d out_sel", m), 32'(os[m]), 32'd0);
            end
        end
        reset = 1'b0;

        // Round-robin rotates 0..3 twice; fixed priority drains lowest index first.
        for (int i = 0; i < 8; i++) begin
            cyc();
            lit("rr fair", 1, 1'b1, i % 4, 8'hA0 + 8'(i % 4));
            lit("fp order", 0, 1'b1, i / 2, 8'hA0 + 8'(i / 2));
        end
        cyc();
        lit("drained", 0, 1'b0, 0, 8'h00);
        lit("drained", 1, 1'b0, 0, 8'h00);
        repeat (2) cyc();

        // Fixed priority: channel 1 starves channel 3 until it runs dry.
        for (int j = 0; j < 4; j++) push(0, 1, 8'h11 + 8'(j), 1'b1, 0);
        push(0, 3, 8'h33, 1'b1, 0);
        cyc();
        cyc();
        check("fp ch1 wins in_ready", 32'(rdy[0]), 32'h2);
        lit("fp ch1", 0, 1'b1, 1, 8'h11);
        for (int j = 1; j < 4; j++) begin
            cyc();
            lit("fp ch1", 0, 1'b1, 1, 8'h11 + 8'(j));
        end
        cyc();
        lit("fp ch3 after drop", 0, 1'b1, 3, 8'h33);
        repeat (2) cyc();

        // Packet lock: channel 2 three-beat packet with a two-cycle valid gap.
        push(1, 2, 8'hD0, 1'b0, 0);
        push(1, 2, 8'hD1, 1'b0, 2);
        push(1, 2, 8'hD2, 1'b1, 0);
        cyc();
        push(1, 0, 8'hC0, 1'b1, 0);
        cyc();
        lit("lock beat1", 1, 1'b1, 2, 8'hD0);
        check("lock others wait", 32'(rdy[1]), 32'h0);
        cyc();
        push(1, 3, 8'hE3, 1'b1, 0);
        lit("lock bubble", 1, 1'b0, 0, 8'h00);
        cyc();
        lit("lock bubble", 1, 1'b0, 0, 8'h00);
        check("lock resume in_ready", 32'(rdy[1]), 32'h4);
        cyc();
        lit("lock beat2", 1, 1'b1, 2, 8'hD1);
        cyc();
        lit("lock beat3", 1, 1'b1, 2, 8'hD2);
        check("lock beat3 last", 32'(ol[1]), 32'd1);
        cyc();
        lit("ptr=3 after lock", 1, 1'b1, 3, 8'hE3);
        cyc();
        lit("ptr wraps to 0", 1, 1'b1, 0, 8'hC0);
        repeat (2) cyc();

        // Backpressure: five stalled cycles, then one beat per cycle with no loss.
        push(1, 1, 8'h51, 1'b0, 0);
        push(1, 1, 8'h52, 1'b0, 0);
        push(1, 1, 8'h53, 1'b1, 0);
        push(1, 2, 8'h62, 1'b1, 0);
        cyc();
        cyc();
        lit("bp first", 1, 1'b1, 1, 8'h51);
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cyc();
            lit("bp hold", 1, 1'b1, 1, 8'h51);
            check("bp in_ready", 32'(rdy[1]), 32'h0);
        end
        out_ready = 1'b1;
        cyc();
        lit("bp resume", 1, 1'b1, 1, 8'h52);
        cyc();
        lit("bp resume", 1, 1'b1, 1, 8'h53);
        cyc();
        lit("bp next ch", 1, 1'b1, 2, 8'h62);
        repeat (2) cyc();

        // Reset mid-packet on channel 1; channel 0 must win after release.
        push(1, 1, 8'h71, 1'b0, 0);
        push(1, 1, 8'h72, 1'b0, 0);
        push(1, 1, 8'h73, 1'b0, 0);
        push(1, 1, 8'h74, 1'b1, 0);
        cyc();
        push(1, 0, 8'h80, 1'b1, 0);
        cyc();
        lit("mid beat1", 1, 1'b1, 1, 8'h71);
        reset = 1'b1;
        cyc();
        lit("mid reset", 1, 1'b0, 0, 8'h00);
        check("mid reset out_sel", 32'(os[1]), 32'd0);
        check("mid reset in_ready", 32'(rdy[1]), 32'h0);
        reset = 1'b0;
        cyc();
        lit("after reset ch0", 1, 1'b1, 0, 8'h80);
        for (int j = 0; j < 3; j++) begin
            cyc();
            lit("after reset ch1", 1, 1'b1, 1, 8'h72 + 8'(j));
        end
        repeat (3) cyc();

        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("sb m%0d ch%0d all delivered", m, c), 32'(rx[m][c]), 32'(tl[m][c]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
